demux16_1_reg: RTL and testbench
================================

Name: demux16_1_reg

Overview:
Registered 1-to-16 demultiplexer. It routes a single serial data bit into one of sixteen held output bits, so it is the write-side counterpart of the 16-to-1 selector that reads one bit out of a 16-bit word.
Two modes are supported:
- Addressed mode: a single write to the bit selected by S16.
- Scan mode: an internal counter steps the destination index, filling bits S16..15 from consecutive serial bits, then signals completion.
The block sits between a serial source and any consumer of a parallel 16-bit word, including the 16-to-1 selector.

Parameters:
CLEAR_ON_START, 0, if 1 a scan start also clears all of Y to 0 on the same edge that enters SCAN.

Ports:
Clock  input  1  system clock; all state changes on the rising edge.
Resetn  input  1  synchronous, active-low reset.
d  input  1  serial data bit to be steered.
S16  input  4  destination index for an addressed write; start index for a scan.
we  input  1  addressed write strobe.
start  input  1  scan start request.
clr  input  1  synchronous clear of Y and abort of any scan.
Y  output  16  held output word, indexed [0:15]; Y[0] is index 0.
busy  output  1  high while a scan is in progress.
done  output  1  one-cycle pulse after the last scan write.

Behaviour:
- One clock domain. Reset is synchronous and active-low.
- Resetn=0 at a rising edge: Y=16'h0000, busy=0, done=0, state=IDLE, cnt=0. Resetn overrides every other input, including mid-scan.
- Internal state: two-state FSM (IDLE, SCAN) and a 4-bit counter cnt.
- All outputs are registered. done defaults to 0 every cycle unless set as below.
- Priority in IDLE: clr > start > we.
- IDLE transitions:
  - clr=1: Y<=0; stay IDLE.
  - start=1: state<=SCAN, cnt<=S16, busy<=1. If CLEAR_ON_START=1, also Y<=0. No bit of d is written on this edge.
  - we=1 (and no start or clr): Y[S16]<=d; all other bits hold. Latency is 1 edge.
  - Otherwise: Y holds.
- SCAN, each edge:
  - clr=1: Y<=0, state<=IDLE, busy<=0, done stays 0 (abort).
  - Otherwise: Y[cnt]<=d.
  - If cnt==15: state<=IDLE, busy<=0, done<=1.
  - Else: cnt<=cnt+1.
  - we and start are ignored while in SCAN; a start during SCAN does not restart the scan.
- Scan timing: start sampled at edge k with S16=s. Data bits are written at edges k+1 .. k+16-s. busy is high from after edge k until edge k+16-s. done is high for the single cycle following edge k+16-s.
- The counter never wraps. A scan from s=15 performs exactly 1 write; a scan from s=0 performs 16 writes.
- Bits below the start index are untouched by a scan (unless CLEAR_ON_START=1).
- A new start is accepted in the same cycle that done is high, since the FSM is back in IDLE.
- Changing S16 during SCAN has no effect.

Test Plan:
1. Reset: Resetn=0 for 2 edges with we=1, d=1, S16=5 -> Y=16'h0000, busy=0, done=0.
2. Addressed writes: d=1 at S16=0, then 5, then 15 (one cycle each); then d=0 at S16=5 -> after the third write Y[0], Y[5], Y[15]=1 and all other bits 0; after the fourth write only Y[0] and Y[15] are 1.
3. Full scan: start with S16=0, then d=1,0,1,0,... for 16 cycles -> Y[0:15]=1010101010101010; busy high for exactly 16 cycles; done high for exactly 1 cycle immediately after the 16th write.
4. Partial scan: preload Y=16'hFFFF via addressed writes; start with S16=12, d=0 for 4 cycles -> Y[0:11] stay 1, Y[12:15]=0; done occurs 4 cycles after start. Repeat with CLEAR_ON_START=1 -> Y[0:11]=0.
5. Abort and ignore:
   - Scan from 0, assert we=1 with S16=3 at cycle 2 -> ignored; scan continues unchanged.
   - Assert clr at cycle 5 -> Y=0 and busy=0 on the next edge; done never asserts.
   - Resetn=0 mid-scan -> same outcome as the clr abort.
6. Priority and back-to-back:
   - Assert start and we together in IDLE -> scan starts; Y is not written on that edge.
   - Assert start again in the done cycle -> a second scan begins; busy rises on the next edge.

Source files
------------

// File: rtl/demux16_1_reg.sv
// demux16_1_reg: registered 1-to-16 demultiplexer with addressed writes and
// a counter-driven scan mode that fills Y[S16..15] from consecutive serial bits.
`default_nettype none

module demux16_1_reg #(
  parameter bit CLEAR_ON_START = 1'b0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        d,
  input  logic [3:0]  S16,
  input  logic        we,
  input  logic        start,
  input  logic        clr,
  output logic [0:15] Y,
  output logic        busy,
  output logic        done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [0:15] y_n;
  logic        busy_n;
  logic        done_n;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
      cnt   <= 4'd0;
      Y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      Y     <= y_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    y_n     = Y;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          y_n = '0;
        end else if (start) begin
          // The start edge only arms the scan; the first data bit lands next edge.
          state_n = SCAN;
          cnt_n   = S16;
          busy_n  = 1'b1;
          if (CLEAR_ON_START) y_n = '0;
        end else if (we) begin
          y_n[S16] = d;
        end
      end
      SCAN: begin
        if (clr) begin
          y_n     = '0;
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          y_n[cnt] = d;
          // Terminate at the top index instead of wrapping back to 0.
          if (cnt == 4'd15) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_demux16_1_reg.sv
// Self-checking bench for demux16_1_reg: two instances (CLEAR_ON_START 0 and 1)
// share stimulus; a reference model feeds a scoreboard queue, plus fixed vectors.
`default_nettype none

module tb_demux16_1_reg;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        d = 1'b0;
  logic [3:0]  s16 = 4'd0;
  logic        we = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic [0:15] y0, y1;
  logic        busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  demux16_1_reg #(.CLEAR_ON_START(1'b0)) dut0 (
    .Clock(clk), .Resetn(rstn), .d(d), .S16(s16), .we(we), .start(start),
    .clr(clr), .Y(y0), .busy(busy0), .done(done0)
  );

  demux16_1_reg #(.CLEAR_ON_START(1'b1)) dut1 (
    .Clock(clk), .Resetn(rstn), .d(d), .S16(s16), .we(we), .start(start),
    .clr(clr), .Y(y1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [0:15] y0;
    logic [0:15] y1;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct {
    logic        rn;
    logic        dd;
    logic [3:0]  ss;
    logic        w;
    logic        st;
    logic        c;
    logic [15:0] y;
    logic        b;
    logic        dn;
  } vec_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  logic [0:15] m_y0 = '0, m_y1 = '0;
  logic        m_scan = 1'b0, m_done = 1'b0;
  int          m_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rn, input logic dd, input logic [3:0] ss,
                     input logic w, input logic st, input logic c);
    exp_t e;
    rstn = rn; d = dd; s16 = ss; we = w; start = st; clr = c;
    m_done = 1'b0;
    if (!rn) begin
      m_y0 = '0; m_y1 = '0; m_scan = 1'b0;
    end else if (!m_scan) begin
      if (c) begin
        m_y0 = '0; m_y1 = '0;
      end else if (st) begin
        m_scan = 1'b1; m_idx = int'(ss); m_y1 = '0;
      end else if (w) begin
        m_y0[ss] = dd; m_y1[ss] = dd;
      end
    end else begin
      if (c) begin
        m_y0 = '0; m_y1 = '0; m_scan = 1'b0;
      end else begin
        m_y0[m_idx] = dd; m_y1[m_idx] = dd;
        if (m_idx == 15) begin
          m_scan = 1'b0; m_done = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
    e.y0 = m_y0; e.y1 = m_y1; e.busy = m_scan; e.done = m_done;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_y0", 32'(y0), 32'(e.y0));
    chk("sb_y1", 32'(y1), 32'(e.y1));
    chk("sb_busy0", 32'(busy0), 32'(e.busy));
    chk("sb_done0", 32'(done0), 32'(e.done));
    chk("sb_busy1", 32'(busy1), 32'(e.busy));
    chk("sb_done1", 32'(done1), 32'(e.done));
  endtask

  initial begin
    vec_t tbl[6];
    int   nbusy, ndone;

    // Reset with write attempts, then addressed writes to 0, 5, 15 and clear of 5
    tbl[0] = '{1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 16'h8400, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 16'h8401, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'd5,  1'b1, 1'b0, 1'b0, 16'h8001, 1'b0, 1'b0};

    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].rn, tbl[i].dd, tbl[i].ss, tbl[i].w, tbl[i].st, tbl[i].c);
      chk($sformatf("vec%0d_y", i), 32'(y0), 32'(tbl[i].y));
      chk($sformatf("vec%0d_busy", i), 32'(busy0), 32'(tbl[i].b));
      chk($sformatf("vec%0d_done", i), 32'(done0), 32'(tbl[i].dn));
    end

    // Full scan from index 0 with alternating data
    cyc(1, 0, 4'd0, 0, 1, 0);
    chk("full_start_y_held", 32'(y0), 32'h8001);
    nbusy = (busy0 === 1'b1) ? 1 : 0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, (i % 2 == 0) ? 1'b1 : 1'b0, 4'd7, 0, 0, 0);
      if (busy0 === 1'b1) nbusy++;
      if (done0 === 1'b1) ndone++;
      if (i == 15) chk("full_done_after_16th", 32'(done0), 32'd1);
    end
    chk("full_y", 32'(y0), 32'hAAAA);
    chk("full_busy_cycles", 32'(nbusy), 32'd16);
    chk("full_done_count", 32'(ndone), 32'd1);
    cyc(1, 0, 4'd0, 0, 0, 0);
    chk("full_done_drops", 32'(done0), 32'd0);

    // Partial scan from 12 over a preloaded all-ones word
    for (int i = 0; i < 16; i++) cyc(1, 1, 4'(i), 1, 0, 0);
    chk("preload_y", 32'(y0), 32'hFFFF);
    cyc(1, 1, 4'd12, 0, 1, 0);
    chk("partial_start_clear1", 32'(y1), 32'h0000);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 4'd0, 0, 0, 0);
      if (i < 3) chk("partial_no_early_done", 32'(done0), 32'd0);
    end
    chk("partial_done_at_4", 32'(done0), 32'd1);
    chk("partial_y_keep_low", 32'(y0), 32'hFFF0);
    chk("partial_y_clear_on_start", 32'(y1), 32'h0000);

    // Scan with an ignored write, then clr abort
    cyc(1, 0, 4'd0, 0, 0, 1);
    cyc(1, 0, 4'd0, 0, 1, 0);
    cyc(1, 1, 4'd0, 0, 0, 0);
    cyc(1, 1, 4'd3, 1, 0, 0);
    chk("ignore_we_in_scan", 32'(y0), 32'hC000);
    cyc(1, 1, 4'd0, 0, 0, 0);
    cyc(1, 1, 4'd0, 0, 0, 0);
    cyc(1, 1, 4'd0, 0, 0, 1);
    chk("abort_clr_y", 32'(y0), 32'h0000);
    chk("abort_clr_busy", 32'(busy0), 32'd0);
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(1, 1, 4'd0, 0, 0, 0);
      if (done0 === 1'b1) ndone++;
    end
    chk("abort_clr_no_done", 32'(ndone), 32'd0);

    // Reset mid-scan
    cyc(1, 0, 4'd0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 4'd0, 0, 0, 0);
    cyc(0, 1, 4'd0, 0, 0, 0);
    chk("abort_rst_y", 32'(y0), 32'h0000);
    chk("abort_rst_busy", 32'(busy0), 32'd0);
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(1, 1, 4'd0, 0, 0, 0);
      if (done0 === 1'b1) ndone++;
    end
    chk("abort_rst_no_done", 32'(ndone), 32'd0);

    // start beats we; back-to-back start in the done cycle
    cyc(1, 1, 4'd14, 1, 1, 0);
    chk("start_over_we_y", 32'(y0), 32'h0000);
    chk("start_over_we_busy", 32'(busy0), 32'd1);
    cyc(1, 1, 4'd0, 0, 0, 0);
    cyc(1, 1, 4'd0, 0, 0, 0);
    chk("b2b_first_done", 32'(done0), 32'd1);
    chk("b2b_first_y", 32'(y0), 32'h0003);
    cyc(1, 0, 4'd15, 0, 1, 0);
    chk("b2b_second_busy", 32'(busy0), 32'd1);
    cyc(1, 0, 4'd0, 0, 0, 0);
    chk("b2b_second_done", 32'(done0), 32'd1);
    chk("b2b_second_y", 32'(y0), 32'h0002);
    cyc(1, 0, 4'd0, 0, 0, 0);
    chk("b2b_idle_busy", 32'(busy0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
